// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - shared ImmSrc codes, field positions, range limits and FIFO entry type
package inst_encoder_pkg;

  // ImmSrc selector codes; 101..111 all mean R-type (no immediate)
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_R = 3'b101;

  // Fixed instruction field positions
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  // Representable immediate ranges (B/J also require an even offset)
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -(1 << 20);
  localparam int IMM21_MAX = (1 << 20) - 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } enc_entry_t;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// rtl/inst_enc_fifo.sv - small output FIFO holding encoded words with address and error tag
module inst_enc_fifo
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  enc_entry_t       wr_data_i,
  input  logic             rd_en_i,
  output enc_entry_t       rd_data_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  enc_entry_t       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_rd;

  // Pointer and occupancy next state; a read of an empty FIFO is ignored
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_rd    = rd_en_i && (count_q != '0);
    if (wr_en_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en_i, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; flush empties the FIFO without touching storage
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written at the tail on every accepted write
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - packs RISC-V fields and immediates into address-tagged instruction words
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic [2:0]  ImmSrc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] err_cnt
);
  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

  logic             accept;
  logic [31:0]      enc_inst;
  logic             enc_err;
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_inst_q, s1_inst_d;
  logic             s1_err_q, s1_err_d;
  logic [29:0]      seq_q, seq_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             fifo_wr, fifo_rd;
  enc_entry_t       fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;

  // Accept only while the FIFO can absorb both the s1 word and a new one; out_ready is not involved
  always_comb begin
    occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid_q};
    in_ready  = !rst && !clear && (occupancy < DEPTH_W);
  end

  assign accept = in_valid && in_ready;

  // Field packing and immediate range check; out-of-range immediates still emit truncated bits
  always_comb begin
    enc_inst = '0;
    enc_err  = 1'b0;
    enc_inst[OPCODE_LSB +: 7] = opcode;
    case (ImmSrc)
      IMM_I: begin
        enc_inst[RD_LSB +: 5]     = rd;
        enc_inst[FUNCT3_LSB +: 3] = funct3;
        enc_inst[RS1_LSB +: 5]    = rs1;
        enc_inst[31:20]           = imm[11:0];
        enc_err = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      IMM_S: begin
        enc_inst[FUNCT3_LSB +: 3] = funct3;
        enc_inst[RS1_LSB +: 5]    = rs1;
        enc_inst[RS2_LSB +: 5]    = rs2;
        enc_inst[31:25]           = imm[11:5];
        enc_inst[11:7]            = imm[4:0];
        enc_err = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      IMM_B: begin
        enc_inst[FUNCT3_LSB +: 3] = funct3;
        enc_inst[RS1_LSB +: 5]    = rs1;
        enc_inst[RS2_LSB +: 5]    = rs2;
        enc_inst[31]              = imm[12];
        enc_inst[30:25]           = imm[10:5];
        enc_inst[11:8]            = imm[4:1];
        enc_inst[7]               = imm[11];
        enc_err = imm[0] || !in_range(imm, IMM13_MIN, IMM13_MAX);
      end
      IMM_J: begin
        enc_inst[RD_LSB +: 5]     = rd;
        enc_inst[31]              = imm[20];
        enc_inst[30:21]           = imm[10:1];
        enc_inst[20]              = imm[11];
        enc_inst[19:12]           = imm[19:12];
        enc_err = imm[0] || !in_range(imm, IMM21_MIN, IMM21_MAX);
      end
      IMM_U: begin
        enc_inst[RD_LSB +: 5]     = rd;
        enc_inst[31:12]           = imm[31:12];
        enc_err = (imm[11:0] != 12'h000);
      end
      default: begin
        enc_inst[RD_LSB +: 5]     = rd;
        enc_inst[FUNCT3_LSB +: 3] = funct3;
        enc_inst[RS1_LSB +: 5]    = rs1;
        enc_inst[RS2_LSB +: 5]    = rs2;
        enc_inst[FUNCT7_LSB +: 7] = funct7;
      end
    endcase
  end

  // The s1 word moves into the FIFO the cycle after acceptance unless a clear drops it
  assign fifo_wr = s1_valid_q && !clear;
  assign fifo_rd = out_valid && out_ready;

  // Next state for s1, the address sequence and the saturating error counter (kept across clear)
  always_comb begin
    s1_valid_d = accept;
    s1_inst_d  = s1_inst_q;
    s1_err_d   = s1_err_q;
    seq_d      = seq_q;
    err_cnt_d  = err_cnt_q;
    if (accept) begin
      s1_inst_d = enc_inst;
      s1_err_d  = enc_err;
    end
    if (clear) begin
      seq_d = '0;
    end else if (fifo_wr) begin
      seq_d = seq_q + 30'd1;
      if (s1_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Stage, sequence and error-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_inst_q  <= '0;
      s1_err_q   <= 1'b0;
      seq_q      <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_inst_q  <= s1_inst_d;
      s1_err_q   <= s1_err_d;
      seq_q      <= seq_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Address tag is fixed at FIFO write time; a 30-bit word index wraps the byte address mod 2^32
  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.inst = s1_inst_q;
    fifo_wdata.addr = BASE_ADDR + {seq_q, 2'b00};
    fifo_wdata.err  = s1_err_q;
  end

  inst_enc_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (clear),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count)
  );

  // Head outputs read as zero whenever the FIFO is empty
  always_comb begin
    out_valid = (fifo_count != '0);
    out_inst  = out_valid ? fifo_rdata.inst : 32'h0;
    out_addr  = out_valid ? fifo_rdata.addr : 32'h0;
    out_err   = out_valid && fifo_rdata.err;
  end

  assign err_cnt = err_cnt_q;

endmodule
